// File: rtl/mem_wb_writeback.sv
// MEM/WB writeback stage: registers ALU result or load data onto the register-file write port.
// Optional LOAD_EXT_EN enables byte/half selection and sign/zero extension of load data.
module mem_wb_writeback #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [REG_AW-1:0] ex_write_reg,
  input  logic              ex_reg_write,
  input  logic              ex_mem_to_reg,
  input  logic [2:0]        ex_load_type,
  input  logic              flush,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              mem_stall,
  output logic              mem_err,
  output logic              wb_reg_write,
  output logic [REG_AW-1:0] wb_write_reg,
  output logic [DATA_W-1:0] wb_write_data
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [REG_AW-1:0]   lat_reg_q, lat_reg_d;
  logic                lat_we_q, lat_we_d;
  logic                wb_we_q, wb_we_d;
  logic [REG_AW-1:0]   wb_reg_q, wb_reg_d;
  logic [DATA_W-1:0]   wb_data_q, wb_data_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   idle_load_data;
  logic [DATA_W-1:0]   wait_load_data;
  logic                accepted;
  logic                ex_we;

`ifdef LOAD_EXT_EN
  logic [1:0] lat_off_q;
  logic [2:0] lat_type_q;

  function automatic logic [DATA_W-1:0] load_ext(input logic [DATA_W-1:0] rdata,
                                                 input logic [1:0]        off,
                                                 input logic [2:0]        typ);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[8*off +: 8];
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (typ)
      3'b001:  load_ext = {{(DATA_W-8){b[7]}}, b};
      3'b010:  load_ext = {{(DATA_W-8){1'b0}}, b};
      3'b011:  load_ext = {{(DATA_W-16){h[15]}}, h};
      3'b100:  load_ext = {{(DATA_W-16){1'b0}}, h};
      default: load_ext = rdata;
    endcase
  endfunction

  // Offset and type must survive the WAIT period along with the destination.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_off_q  <= 2'b00;
      lat_type_q <= 3'b000;
    end else if (state_q == IDLE && accepted && ex_mem_to_reg && !mem_ready) begin
      lat_off_q  <= ex_alu_result[1:0];
      lat_type_q <= ex_load_type;
    end
  end

  assign idle_load_data = load_ext(mem_rdata, ex_alu_result[1:0], ex_load_type);
  assign wait_load_data = load_ext(mem_rdata, lat_off_q, lat_type_q);
`else
  logic unused_load_type;
  assign unused_load_type = ^ex_load_type;
  assign idle_load_data   = mem_rdata;
  assign wait_load_data   = mem_rdata;
`endif

  assign accepted = ex_valid & ~flush;
  assign ex_we    = ex_reg_write & (ex_write_reg != '0);

  assign mem_stall = ((state_q == IDLE) & ex_valid & ex_mem_to_reg & ~mem_ready & ~flush)
                   | ((state_q == WAIT) & ~mem_ready & ~flush);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lat_reg_d = lat_reg_q;
    lat_we_d  = lat_we_q;
    wb_we_d   = 1'b0;
    wb_reg_d  = wb_reg_q;
    wb_data_d = wb_data_q;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accepted) begin
          if (!ex_mem_to_reg) begin
            wb_we_d   = ex_we;
            wb_reg_d  = ex_write_reg;
            wb_data_d = ex_alu_result;
          end else if (mem_ready) begin
            wb_we_d   = ex_we;
            wb_reg_d  = ex_write_reg;
            wb_data_d = idle_load_data;
          end else begin
            lat_reg_d = ex_write_reg;
            lat_we_d  = ex_we;
            cnt_d     = 8'd1;
            state_d   = WAIT;
          end
        end
      end
      WAIT: begin
        // Flush outranks a same-cycle mem_ready: the load is dead either way.
        if (flush) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else if (mem_ready) begin
          wb_we_d   = lat_we_q;
          wb_reg_d  = lat_reg_q;
          wb_data_d = wait_load_data;
          state_d   = IDLE;
          cnt_d     = 8'd0;
        end else if (cnt_q == MAX_WAIT_C) begin
          err_d   = 1'b1;
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      lat_reg_q <= '0;
      lat_we_q  <= 1'b0;
      wb_we_q   <= 1'b0;
      wb_reg_q  <= '0;
      wb_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lat_reg_q <= lat_reg_d;
      lat_we_q  <= lat_we_d;
      wb_we_q   <= wb_we_d;
      wb_reg_q  <= wb_reg_d;
      wb_data_q <= wb_data_d;
      err_q     <= err_d;
    end
  end

  assign mem_err       = err_q;
  assign wb_reg_write  = wb_we_q;
  assign wb_write_reg  = wb_reg_q;
  assign wb_write_data = wb_data_q;

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Directed bench for mem_wb_writeback: ALU path, waited loads, timeout, flush, reg-0, load extension.
module tb_mem_wb_writeback;

  localparam int DATA_W   = 32;
  localparam int REG_AW   = 5;
  localparam int MAX_WAIT = 15;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ex_valid;
  logic [DATA_W-1:0] ex_alu_result;
  logic [REG_AW-1:0] ex_write_reg;
  logic              ex_reg_write;
  logic              ex_mem_to_reg;
  logic [2:0]        ex_load_type;
  logic              flush;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              mem_stall;
  logic              mem_err;
  logic              wb_reg_write;
  logic [REG_AW-1:0] wb_write_reg;
  logic [DATA_W-1:0] wb_write_data;

  int vectors = 0;
  int errors  = 0;

  mem_wb_writeback #(.DATA_W(DATA_W), .REG_AW(REG_AW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_valid      (ex_valid),
    .ex_alu_result (ex_alu_result),
    .ex_write_reg  (ex_write_reg),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_to_reg (ex_mem_to_reg),
    .ex_load_type  (ex_load_type),
    .flush         (flush),
    .mem_rdata     (mem_rdata),
    .mem_ready     (mem_ready),
    .mem_stall     (mem_stall),
    .mem_err       (mem_err),
    .wb_reg_write  (wb_reg_write),
    .wb_write_reg  (wb_write_reg),
    .wb_write_data (wb_write_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bubble();
    ex_valid = 1'b0; ex_alu_result = '0; ex_write_reg = '0; ex_reg_write = 1'b0;
    ex_mem_to_reg = 1'b0; ex_load_type = 3'b000; flush = 1'b0;
  endtask

  task automatic present(input logic m2r, input logic [4:0] rd, input logic [31:0] alu,
                         input logic [2:0] lt);
    ex_valid = 1'b1; ex_mem_to_reg = m2r; ex_write_reg = rd; ex_reg_write = 1'b1;
    ex_alu_result = alu; ex_load_type = lt; flush = 1'b0;
  endtask

  task automatic ext_case(input string tag, input logic [1:0] off, input logic [2:0] lt,
                          input logic [31:0] exp_ext);
    logic [31:0] exp;
`ifdef LOAD_EXT_EN
    exp = exp_ext;
`else
    exp = 32'h80FF7F01;
`endif
    present(1'b1, 5'd12, {30'h40, off}, lt);
    mem_rdata = 32'h80FF7F01; mem_ready = 1'b1;
    tick();
    bubble(); mem_ready = 1'b0;
    chk({tag, "_we"}, {31'd0, wb_reg_write}, 32'd1);
    chk({tag, "_data"}, wb_write_data, exp);
  endtask

  initial begin
    rst_n = 1'b0; mem_rdata = '0; mem_ready = 1'b0;
    bubble();
    #3;
    chk("rst_we", {31'd0, wb_reg_write}, 32'd0);
    chk("rst_reg", {27'd0, wb_write_reg}, 32'd0);
    chk("rst_data", wb_write_data, 32'd0);
    chk("rst_err", {31'd0, mem_err}, 32'd0);
    chk("rst_stall", {31'd0, mem_stall}, 32'd0);
    #9 rst_n = 1'b1;

    // ALU op, one-cycle latency
    tick();
    present(1'b0, 5'd5, 32'h12345678, 3'b000);
    tick();
    bubble();
    chk("alu_we", {31'd0, wb_reg_write}, 32'd1);
    chk("alu_reg", {27'd0, wb_write_reg}, 32'd5);
    chk("alu_data", wb_write_data, 32'h12345678);
    tick();
    chk("bubble_we", {31'd0, wb_reg_write}, 32'd0);
    chk("bubble_hold", wb_write_data, 32'h12345678);

    // Load with mem_ready low for three cycles
    present(1'b1, 5'd7, 32'h100, 3'b000);
    #1 chk("ld_stall0", {31'd0, mem_stall}, 32'd1);
    tick();
    chk("ld_stall1", {31'd0, mem_stall}, 32'd1);
    chk("ld_nowe1", {31'd0, wb_reg_write}, 32'd0);
    tick();
    chk("ld_stall2", {31'd0, mem_stall}, 32'd1);
    tick();
    bubble(); mem_ready = 1'b1; mem_rdata = 32'hCAFEBABE;
    #1 chk("ld_stall_ready", {31'd0, mem_stall}, 32'd0);
    tick();
    mem_ready = 1'b0;
    chk("ld_we", {31'd0, wb_reg_write}, 32'd1);
    chk("ld_reg", {27'd0, wb_write_reg}, 32'd7);
    chk("ld_data", wb_write_data, 32'hCAFEBABE);
    tick();
    chk("ld_after_we", {31'd0, wb_reg_write}, 32'd0);

    // Timeout
    present(1'b1, 5'd9, 32'h200, 3'b000);
    tick();
    bubble();
    for (int i = 1; i <= MAX_WAIT; i++) begin
      chk($sformatf("to_stall_%0d", i), {31'd0, mem_stall}, 32'd1);
      chk($sformatf("to_err_%0d", i), {31'd0, mem_err}, 32'd0);
      tick();
    end
    chk("to_err", {31'd0, mem_err}, 32'd1);
    chk("to_nowe", {31'd0, wb_reg_write}, 32'd0);
    chk("to_stall_drop", {31'd0, mem_stall}, 32'd0);
    chk("to_reg_hold", {27'd0, wb_write_reg}, 32'd7);
    tick();
    chk("to_err_pulse", {31'd0, mem_err}, 32'd0);

    // Flush in WAIT together with mem_ready
    present(1'b1, 5'd10, 32'h300, 3'b000);
    tick();
    bubble(); flush = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h11111111;
    #1 chk("fl_stall", {31'd0, mem_stall}, 32'd0);
    tick();
    flush = 1'b0; mem_ready = 1'b0;
    chk("fl_nowe", {31'd0, wb_reg_write}, 32'd0);
    chk("fl_data_hold", wb_write_data, 32'hCAFEBABE);
    present(1'b0, 5'd3, 32'hA5A5A5A5, 3'b000);
    tick();
    bubble();
    chk("fl_idle_we", {31'd0, wb_reg_write}, 32'd1);
    chk("fl_idle_data", wb_write_data, 32'hA5A5A5A5);

    // Flush in IDLE, then write to register 0
    present(1'b0, 5'd4, 32'h0BADF00D, 3'b000); flush = 1'b1;
    tick();
    bubble();
    chk("fl_idle_kill_we", {31'd0, wb_reg_write}, 32'd0);
    chk("fl_idle_kill_data", wb_write_data, 32'hA5A5A5A5);
    present(1'b0, 5'd0, 32'h0000DEAD, 3'b000);
    tick();
    bubble();
    chk("r0_we", {31'd0, wb_reg_write}, 32'd0);

    // Load extension
    ext_case("lw_off1", 2'd1, 3'b000, 32'h80FF7F01);
    ext_case("lb_off3", 2'd3, 3'b001, 32'hFFFFFF80);
    ext_case("lbu_off3", 2'd3, 3'b010, 32'h00000080);
    ext_case("lb_off1", 2'd1, 3'b001, 32'h0000007F);
    ext_case("lh_off2", 2'd2, 3'b011, 32'hFFFF80FF);
    ext_case("lhu_off0", 2'd0, 3'b100, 32'h00007F01);

    // Reset mid-WAIT
    present(1'b1, 5'd8, 32'h400, 3'b000);
    tick();
    bubble();
    #2 rst_n = 1'b0;
    #1;
    chk("rw_we", {31'd0, wb_reg_write}, 32'd0);
    chk("rw_data", wb_write_data, 32'd0);
    chk("rw_reg", {27'd0, wb_write_reg}, 32'd0);
    chk("rw_stall", {31'd0, mem_stall}, 32'd0);
    #2 rst_n = 1'b1;
    mem_ready = 1'b1; mem_rdata = 32'h55555555;
    tick();
    mem_ready = 1'b0;
    chk("rw_after_we", {31'd0, wb_reg_write}, 32'd0);
    chk("rw_after_err", {31'd0, mem_err}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
